fifo_frame_reader: RTL and testbench
====================================

FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 16, maximum legal payload length in bytes (1..255).
REQ-002 SHALL provide port clkb  input  1  read-domain clock; all logic on its rising edge.
REQ-003 SHALL provide port reset_clkb  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port empty  input  1  FIFO read-side empty flag.
REQ-005 SHALL provide port rd  output  1  FIFO read strobe, one byte per asserted cycle.
REQ-006 SHALL provide port dout_clkb  input  8  FIFO read data, valid the cycle after rd.
REQ-007 SHALL provide port byte_out  output  8  payload byte to downstream.
REQ-008 SHALL provide port byte_valid  output  1  byte_out/sof/eof valid.
REQ-009 SHALL provide port byte_ready  input  1  downstream accepts when byte_valid and byte_ready high.
REQ-010 SHALL provide port sof  output  1  first payload byte of frame.
REQ-011 SHALL provide port eof  output  1  last payload byte of frame.
REQ-012 SHALL provide port frame_done  output  1  one-cycle pulse after checksum byte is checked.
REQ-013 SHALL provide port frame_err  output  1  qualified by frame_done; 1 = checksum mismatch.
REQ-014 SHALL provide port len_err  output  1  one-cycle pulse: illegal header discarded.

Function
REQ-015 SHALL parse frames from the FIFO: LEN byte, LEN payload bytes, CHK byte; CHK = 8-bit modulo-256 sum of payload bytes.
REQ-016 SHALL treat FIFO read latency as exactly one cycle: byte on dout_clkb captured in cycle after rd.
REQ-017 SHALL have at most one read outstanding; rd never asserted in the cycle after rd (peak throughput one byte per two cycles).
REQ-018 SHALL assert rd only when empty=0, no read pending, and (state not S_PAY or output register free or being accepted this cycle).
REQ-019 SHALL implement states S_HDR, S_PAY, S_CHK; reset and end of every frame return to S_HDR.
REQ-020 S_HDR: captured byte 1..MAX_LEN -> load remaining count = LEN, clear sum, go S_PAY; 0 or >MAX_LEN -> pulse len_err next cycle, stay S_HDR.
REQ-021 S_PAY: each captured byte loads output register (byte_valid=1), adds to sum (wrap mod 256), decrements count; sof=1 on first, eof=1 when count reaches 0; after last byte go S_CHK.
REQ-022 byte_out, sof, eof SHALL hold stable while byte_valid=1 and byte_ready=0; byte_valid clears on acceptance unless a new byte is captured that cycle.
REQ-023 LEN=1 SHALL assert sof and eof together on the single payload byte.
REQ-024 S_CHK: captured byte compared with sum; next cycle frame_done=1, frame_err=(mismatch); go S_HDR; CHK read SHALL not wait on downstream acceptance of the eof byte.
REQ-025 Header and checksum bytes SHALL never appear on byte_out.
REQ-026 empty=1 SHALL stall parsing indefinitely with state, count and sum preserved; no timeout.
REQ-027 dout_clkb SHALL be ignored in any cycle not following an rd.

Reset
REQ-028 reset_clkb=1 SHALL force next cycle: state S_HDR, rd=0, byte_valid=0, sof=0, eof=0, frame_done=0, frame_err=0, len_err=0, byte_out=0, count=0, sum=0, pending=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; a read pending when reset asserts SHALL be discarded, not parsed as a header.
REQ-030 rd SHALL remain 0 while reset_clkb=1.

Verification
REQ-031 FIFO holds 03 10 20 30 60, byte_ready=1 -> byte_out 10(sof),20,30(eof); frame_done=1, frame_err=0; rd never in consecutive cycles.
REQ-032 FIFO holds 02 AA BB 00 -> payload AA(sof), BB(eof); sum 0x65 != 00 -> frame_done=1, frame_err=1.
REQ-033 FIFO holds 00 then 11 (MAX_LEN=16) then 01 55 55 -> len_err pulses twice; frame of one byte 55 with sof=eof=1, frame_err=0.
REQ-034 03 10 20 30 60 with byte_ready=0 for 10 cycles -> byte_out=10 held stable, rd=0 while output register full; rest of frame follows unchanged on release.
REQ-035 reset_clkb pulsed after LEN=04 and two payload bytes -> outputs at reset values; next bytes 01 7F 7F parsed as a fresh frame, frame_err=0.
REQ-036 empty toggled randomly during 05 01 02 03 04 05 0F -> five bytes in order, sof on 01, eof on 05, frame_err=0.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pulls LEN / payload / CHK frames out of a one-cycle-latency
// FIFO read port. It streams the payload bytes downstream with sof/eof framing,
// checks the modulo-256 checksum, and discards illegal length headers.
`timescale 1ns/1ps

module fifo_frame_reader #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       clkb,
  input  logic       reset_clkb,
  input  logic       empty,
  output logic       rd,
  input  logic [7:0] dout_clkb,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       sof,
  output logic       eof,
  output logic       frame_done,
  output logic       frame_err,
  output logic       len_err
);

  localparam int unsigned DataW = 8;
  localparam logic [DataW-1:0] MaxLenB = DataW'(MAX_LEN);

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_CHK = 2'd2
  } state_e;

  state_e             state_q;
  logic               pend_q;
  logic [DataW-1:0]   cnt_q;
  logic [DataW-1:0]   sum_q;
  logic               first_q;
  logic [DataW-1:0]   byte_q;
  logic               bv_q;
  logic               sof_q;
  logic               eof_q;
  logic               done_q;
  logic               ferr_q;
  logic               lerr_q;

  logic               accept_c;
  logic               out_room_c;
  logic               hdr_ok_c;
  logic               last_c;
  logic [DataW-1:0]   sum_d;
  logic [DataW-1:0]   cnt_d;

  // Downstream handshake and payload-side back-pressure qualifier for the FIFO read.
  always_comb begin
    accept_c   = bv_q & byte_ready;
    out_room_c = (state_q != S_PAY) | ~bv_q | byte_ready;
  end

  // Data-path helpers for the byte being captured this cycle.
  always_comb begin
    hdr_ok_c = (dout_clkb != '0) && (dout_clkb <= MaxLenB);
    last_c   = (cnt_q == DataW'(1));
    sum_d    = sum_q + dout_clkb;
    cnt_d    = cnt_q - DataW'(1);
  end

  // The read strobe must react to empty in the same cycle: the flag can rise
  // without any read from this side, so it cannot be pipelined. A read is also
  // held off while one is in flight or while the payload output is blocked.
  always_comb begin
    rd = ~reset_clkb & ~empty & ~pend_q & out_room_c;
  end

  // Frame parser. Bytes are consumed only in the cycle after a read, so a stale
  // dout_clkb never affects state and a read issued before reset is dropped.
  always_ff @(posedge clkb) begin
    if (reset_clkb) begin
      state_q <= S_HDR;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      first_q <= 1'b0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      pend_q <= rd;
      done_q <= 1'b0;
      lerr_q <= 1'b0;

      if (accept_c) begin
        bv_q  <= 1'b0;
        sof_q <= 1'b0;
        eof_q <= 1'b0;
      end

      if (pend_q) begin
        case (state_q)
          S_HDR: begin
            if (hdr_ok_c) begin
              cnt_q   <= dout_clkb;
              sum_q   <= '0;
              first_q <= 1'b1;
              state_q <= S_PAY;
            end else begin
              lerr_q  <= 1'b1;
            end
          end
          S_PAY: begin
            // Loading here overrides the acceptance clear above.
            byte_q  <= dout_clkb;
            bv_q    <= 1'b1;
            sof_q   <= first_q;
            eof_q   <= last_c;
            first_q <= 1'b0;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            if (last_c) begin
              state_q <= S_CHK;
            end
          end
          S_CHK: begin
            done_q  <= 1'b1;
            ferr_q  <= (dout_clkb != sum_q);
            state_q <= S_HDR;
          end
          default: begin
            state_q <= S_HDR;
          end
        endcase
      end
    end
  end

  // Registered outputs.
  always_comb begin
    byte_out   = byte_q;
    byte_valid = bv_q;
    sof        = sof_q;
    eof        = eof_q;
    frame_done = done_q;
    frame_err  = ferr_q;
    len_err    = lerr_q;
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: a FIFO model feeds byte streams, a
// frame-level reference model predicts outputs, and a monitor checks the DUT.
`timescale 1ns/1ps

module tb_fifo_frame_reader;

  localparam int unsigned MAX_LEN = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_byte_t;

  logic       clkb = 1'b0;
  logic       reset_clkb = 1'b1;
  logic       empty = 1'b1;
  logic       rd;
  logic [7:0] dout_clkb = 8'h00;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       sof;
  logic       eof;
  logic       frame_done;
  logic       frame_err;
  logic       len_err;

  int         checks = 0;
  int         errors = 0;

  logic [7:0] fifo_q[$];
  exp_byte_t  exp_byte_q[$];
  logic       exp_done_q[$];
  int         exp_lerr = 0;
  logic [7:0] stim[$];

  int         ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit         rand_empty = 1'b0;

  fifo_frame_reader #(.MAX_LEN(MAX_LEN)) dut (
    .clkb       (clkb),
    .reset_clkb (reset_clkb),
    .empty      (empty),
    .rd         (rd),
    .dout_clkb  (dout_clkb),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .sof        (sof),
    .eof        (eof),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .len_err    (len_err)
  );

  always #5 clkb = ~clkb;

  // Reference model: walk the byte stream frame by frame and queue the expected events.
  task automatic model_stream(input logic [7:0] s[$]);
    int         i;
    int         len;
    logic [7:0] sum;
    exp_byte_t  eb;
    i = 0;
    while (i < s.size()) begin
      len = int'(s[i]);
      i++;
      if (len == 0 || len > int'(MAX_LEN)) begin
        exp_lerr++;
        continue;
      end
      sum = 8'h00;
      for (int k = 0; k < len && i < s.size(); k++) begin
        eb.d   = s[i];
        eb.sof = (k == 0);
        eb.eof = (k == len - 1);
        exp_byte_q.push_back(eb);
        sum = sum + s[i];
        i++;
      end
      if (i < s.size()) begin
        exp_done_q.push_back(s[i] != sum);
        i++;
      end
    end
  endtask

  // Issue a stream: predict its outputs, then load it into the FIFO model.
  task automatic send(input logic [7:0] s[$]);
    model_stream(s);
    foreach (s[j]) fifo_q.push_back(s[j]);
  endtask

  // Wait (bounded) until the FIFO is drained and every expected event has been seen.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_byte_q.size() != 0 || exp_done_q.size() != 0
            || exp_lerr != 0) && n < budget) begin
      @(negedge clkb);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: fifo=%0d bytes=%0d dones=%0d lerr=%0d left, expected all 0",
               fifo_q.size(), exp_byte_q.size(), exp_done_q.size(), exp_lerr);
    end
    repeat (4) @(negedge clkb);
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({byte_valid, sof, eof, frame_done, frame_err, len_err, rd, byte_out} != 15'd0) begin
      errors++;
      $display("FAIL %s: bv=%b sof=%b eof=%b done=%b ferr=%b lerr=%b rd=%b byte=%h, expected all 0",
               name, byte_valid, sof, eof, frame_done, frame_err, len_err, rd, byte_out);
    end
  endtask

  // FIFO read port model: pop on rd, present data one cycle later, garbage otherwise.
  initial begin : fifo_driver
    logic rd_s;
    logic gate;
    forever begin
      @(negedge clkb);
      rd_s = rd;
      @(posedge clkb);
      #1;
      if (rd_s && fifo_q.size() != 0) dout_clkb = fifo_q.pop_front();
      else dout_clkb = 8'($urandom);
      gate  = rand_empty && ($urandom_range(0, 2) == 0);
      empty = (fifo_q.size() == 0) || gate;
      case (ready_mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = ($urandom_range(0, 3) != 0);
        default: byte_ready = 1'b0;
      endcase
    end
  end

  // Monitor: protocol rules plus scoreboard pops on every DUT output event.
  initial begin : monitor
    logic       rd_prev;
    logic       hold_prev;
    logic [7:0] b_prev;
    logic       sof_prev;
    logic       eof_prev;
    exp_byte_t  eb;
    logic       ee;
    rd_prev   = 1'b0;
    hold_prev = 1'b0;
    b_prev    = 8'h00;
    sof_prev  = 1'b0;
    eof_prev  = 1'b0;
    forever begin
      @(negedge clkb);
      if (reset_clkb) begin
        checks++;
        if (rd) begin
          errors++;
          $display("FAIL rd_in_reset: rd=%b, expected 0", rd);
        end
      end else begin
        if (rd) begin
          checks++;
          if (empty || rd_prev) begin
            errors++;
            $display("FAIL rd_protocol: rd=1 with empty=%b prev_rd=%b, expected both 0", empty, rd_prev);
          end
        end
        if (hold_prev) begin
          checks++;
          if (!byte_valid || byte_out != b_prev || sof != sof_prev || eof != eof_prev) begin
            errors++;
            $display("FAIL hold_stable: bv=%b byte=%h sof=%b eof=%b, expected bv=1 byte=%h sof=%b eof=%b",
                     byte_valid, byte_out, sof, eof, b_prev, sof_prev, eof_prev);
          end
        end
        if (byte_valid && byte_ready) begin
          checks++;
          if (exp_byte_q.size() == 0) begin
            errors++;
            $display("FAIL byte_unexpected: got %h sof=%b eof=%b, expected no byte", byte_out, sof, eof);
          end else begin
            eb = exp_byte_q.pop_front();
            if (byte_out != eb.d || sof != eb.sof || eof != eb.eof) begin
              errors++;
              $display("FAIL byte_out: got %h sof=%b eof=%b, expected %h sof=%b eof=%b",
                       byte_out, sof, eof, eb.d, eb.sof, eb.eof);
            end
          end
        end
        if (frame_done) begin
          checks++;
          if (exp_done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: frame_done=1 err=%b, expected no frame_done", frame_err);
          end else begin
            ee = exp_done_q.pop_front();
            if (frame_err != ee) begin
              errors++;
              $display("FAIL frame_err: got %b, expected %b", frame_err, ee);
            end
          end
        end
        if (len_err) begin
          checks++;
          if (exp_lerr == 0) begin
            errors++;
            $display("FAIL len_err_unexpected: len_err=1, expected 0");
          end else begin
            exp_lerr--;
          end
        end
      end
      rd_prev   = rd;
      hold_prev = !reset_clkb && byte_valid && !byte_ready;
      b_prev    = byte_out;
      sof_prev  = sof;
      eof_prev  = eof;
    end
  end

  // Hard stop so the run can never hang.
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int len;
    logic [7:0] sum;

    // Reset state.
    repeat (3) @(posedge clkb);
    @(negedge clkb);
    check_reset_values("reset_state");
    @(posedge clkb);
    #1 reset_clkb = 1'b0;

    // Three-byte frame with a correct checksum.
    stim = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    send(stim);
    drain(500);

    // Checksum mismatch.
    stim = '{8'h02, 8'hAA, 8'hBB, 8'h00};
    send(stim);
    drain(500);

    // Zero and oversize headers discarded, then a one-byte frame.
    stim = '{8'h00, 8'h11, 8'h01, 8'h55, 8'h55};
    send(stim);
    drain(500);

    // Downstream stall: first byte held, no reads while the output is full.
    ready_mode = 2;
    repeat (2) @(negedge clkb);
    stim = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    send(stim);
    n = 0;
    while (!byte_valid && n < 50) begin
      @(negedge clkb);
      n++;
    end
    checks++;
    if (!byte_valid) begin
      errors++;
      $display("FAIL stall_wait: byte_valid=%b, expected 1 within 50 cycles", byte_valid);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({rd, byte_valid, sof, byte_out} != {1'b0, 1'b1, 1'b1, 8'h10}) begin
        errors++;
        $display("FAIL stall_hold: rd=%b bv=%b sof=%b byte=%h, expected rd=0 bv=1 sof=1 byte=10",
                 rd, byte_valid, sof, byte_out);
      end
      @(negedge clkb);
    end
    ready_mode = 0;
    drain(500);

    // Reset mid-frame, then a fresh frame.
    stim = '{8'h04, 8'h10, 8'h20};
    send(stim);
    drain(500);
    @(posedge clkb);
    #1 reset_clkb = 1'b1;
    @(posedge clkb);
    @(negedge clkb);
    check_reset_values("midframe_reset");
    @(posedge clkb);
    #1 reset_clkb = 1'b0;
    stim = '{8'h01, 8'h7F, 8'h7F};
    send(stim);
    drain(500);

    // Random empty gaps during a five-byte frame.
    rand_empty = 1'b1;
    stim = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F};
    send(stim);
    drain(1000);

    // Random frames under random empty and ready.
    ready_mode = 1;
    for (int f = 0; f < 30; f++) begin
      stim = {};
      if ($urandom_range(0, 9) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
        stim.push_back(8'(len));
      end else begin
        len = int'($urandom_range(1, MAX_LEN));
        stim.push_back(8'(len));
        sum = 8'h00;
        for (int k = 0; k < len; k++) begin
          stim.push_back(8'($urandom));
          sum = sum + stim[stim.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) stim.push_back(8'($urandom));
        else stim.push_back(sum);
      end
      send(stim);
    end
    drain(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
